// File: rtl/seed_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// seed_request_arbiter_if
//
// Bundles every signal that runs between the seed request arbiter, the
// consumer blocks that ask for seeds and the shared LFSR seed generator.
//
// Signals:
//   req         requesters -> arbiter   per-requester level request
//   rate_sel    requesters -> arbiter   3-bit rate code per requester
//   ack         requesters -> arbiter   per-requester seed accepted
//   gnt         arbiter -> requesters   one-hot grant, zero when idle
//   seed_o      arbiter -> requesters   delivered seed
//   seed_valid  arbiter -> requesters   seed_o valid for the granted requester
//   gen_run     arbiter -> generator    generator start/stop
//   gen_rate    arbiter -> generator    generator rate select
//   gen_seed    generator -> arbiter    generator seed output
//   gen_ready   generator -> arbiter    seed ready, asynchronous to clk
//   busy        arbiter -> system       arbiter is in a transaction
//   timeout_err arbiter -> system       one-cycle pulse when the generator
//                                       never became ready
//
// Modports:
//   master  the arbiter itself
//   slave   the environment (requesters plus generator)
// ---------------------------------------------------------------------------
interface seed_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SEED_W  = 8
);

    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] rate_sel;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   gnt;
    logic [SEED_W-1:0]    seed_o;
    logic                 seed_valid;
    logic                 gen_run;
    logic [2:0]           gen_rate;
    logic [SEED_W-1:0]    gen_seed;
    logic                 gen_ready;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  req, rate_sel, ack, gen_seed, gen_ready,
        output gnt, seed_o, seed_valid, gen_run, gen_rate, busy, timeout_err
    );

    modport slave (
        output req, rate_sel, ack, gen_seed, gen_ready,
        input  gnt, seed_o, seed_valid, gen_run, gen_rate, busy, timeout_err
    );

endinterface

// File: rtl/seed_request_arbiter.sv
// ---------------------------------------------------------------------------
// seed_request_arbiter
//
// Shares one LFSR seed generator among NUM_REQ requesters. A round-robin
// arbiter picks a requester, the generator rate is programmed and allowed to
// settle, the generator is run until it signals ready, and the captured seed
// is handed to the granted requester, which acknowledges it. A timeout
// covers a generator that never becomes ready.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset, released synchronously inside
//   bus      seed_request_arbiter_if.master, all handshake and generator pins
// ---------------------------------------------------------------------------
module seed_request_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SEED_W      = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    seed_request_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        WAIT,
        DELIVER
    } state_e;

    logic [1:0]         rstSync_q;
    logic               rstInt_n;

    logic [1:0]         rdySync_q;
    logic               rdyPrev_q;
    logic               rdyRise;

    state_e             state_q,      state_d;
    logic [IDX_W-1:0]   grantIdx_q,   grantIdx_d;
    logic [IDX_W-1:0]   rrPtr_q,      rrPtr_d;
    logic [NUM_REQ-1:0] gnt_q,        gnt_d;
    logic [SEED_W-1:0]  seed_q,       seed_d;
    logic               seedValid_q,  seedValid_d;
    logic               genRun_q,     genRun_d;
    logic [2:0]         genRate_q,    genRate_d;
    logic [SET_W-1:0]   settle_q,     settle_d;
    logic [TMO_W-1:0]   tmo_q,        tmo_d;
    logic               timeoutErr_q, timeoutErr_d;

    logic [IDX_W-1:0]   winnerIdx;
    logic [IDX_W-1:0]   nextPtr;

    // Adds an offset to a requester index and wraps it back into
    // 0..NUM_REQ-1, which also works when NUM_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] wrapAdd(input logic [IDX_W-1:0] base,
                                                 input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Reset synchronizer: the external reset clears everything at once, but
    // its release is seen by the rest of the design only on a clock edge so
    // no flop leaves reset in the middle of a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstSync_q <= '0;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    // gen_ready comes from another clock domain, so it goes through two
    // flops before use; the third flop remembers the previous synchronized
    // level so a new seed is recognised only on its rising edge.
    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            rdySync_q <= '0;
            rdyPrev_q <= 1'b0;
        end else begin
            rdySync_q <= {rdySync_q[0], bus.gen_ready};
            rdyPrev_q <= rdySync_q[1];
        end
    end

    assign rdyRise = rdySync_q[1] & ~rdyPrev_q;

    // Round-robin pick: scan from the far end of the window back towards
    // rrPtr_q so the last hit written is the first requester at or after
    // the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        winnerIdx = rrPtr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[wrapAdd(rrPtr_q, k)]) begin
                winnerIdx = wrapAdd(rrPtr_q, k);
            end
        end
    end

    assign nextPtr = wrapAdd(grantIdx_q, 1);

    // Next-state and output logic. Every output is registered so the
    // requesters and the generator see clean, glitch-free levels. Any exit
    // from a granted transaction (ack, withdrawal or timeout) moves the
    // pointer past the served requester, which bounds everyone's wait to
    // NUM_REQ-1 transactions. In WAIT a withdrawal wins over everything,
    // and a seed arriving on the timeout's last cycle wins over the timeout.
    always_comb begin
        state_d      = state_q;
        grantIdx_d   = grantIdx_q;
        rrPtr_d      = rrPtr_q;
        gnt_d        = gnt_q;
        seed_d       = seed_q;
        seedValid_d  = seedValid_q;
        genRun_d     = genRun_q;
        genRate_d    = genRate_q;
        settle_d     = settle_q;
        tmo_d        = tmo_q;
        timeoutErr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = CONFIG;
                    grantIdx_d = winnerIdx;
                    gnt_d      = NUM_REQ'(1) << winnerIdx;
                    genRate_d  = bus.rate_sel[3*winnerIdx +: 3];
                    settle_d   = SET_W'(SETTLE_CYC);
                end
            end

            CONFIG: begin
                if (!bus.req[grantIdx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    rrPtr_d = nextPtr;
                end else begin
                    settle_d = settle_q - 1'b1;
                    if (settle_q == SET_W'(1)) begin
                        state_d  = WAIT;
                        genRun_d = 1'b1;
                        tmo_d    = '0;
                    end
                end
            end

            WAIT: begin
                if (!bus.req[grantIdx_q]) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    genRun_d = 1'b0;
                    rrPtr_d  = nextPtr;
                end else if (rdyRise) begin
                    state_d     = DELIVER;
                    seed_d      = bus.gen_seed;
                    seedValid_d = 1'b1;
                    genRun_d    = 1'b0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = IDLE;
                    timeoutErr_d = 1'b1;
                    gnt_d        = '0;
                    genRun_d     = 1'b0;
                    rrPtr_d      = nextPtr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            DELIVER: begin
                if (bus.ack[grantIdx_q] || !bus.req[grantIdx_q]) begin
                    state_d     = IDLE;
                    seedValid_d = 1'b0;
                    gnt_d       = '0;
                    rrPtr_d     = nextPtr;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any transaction silently:
    // outputs drop to zero and no timeout pulse is produced.
    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q      <= IDLE;
            grantIdx_q   <= '0;
            rrPtr_q      <= '0;
            gnt_q        <= '0;
            seed_q       <= '0;
            seedValid_q  <= 1'b0;
            genRun_q     <= 1'b0;
            genRate_q    <= '0;
            settle_q     <= '0;
            tmo_q        <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grantIdx_q   <= grantIdx_d;
            rrPtr_q      <= rrPtr_d;
            gnt_q        <= gnt_d;
            seed_q       <= seed_d;
            seedValid_q  <= seedValid_d;
            genRun_q     <= genRun_d;
            genRate_q    <= genRate_d;
            settle_q     <= settle_d;
            tmo_q        <= tmo_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.seed_o      = seed_q;
    assign bus.seed_valid  = seedValid_q;
    assign bus.gen_run     = genRun_q;
    assign bus.gen_rate    = genRate_q;
    assign bus.timeout_err = timeoutErr_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_seed_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seed_request_arbiter
//
// Drives the arbiter through single requests, round-robin rotation with
// random rates and seeds, timeout, withdrawal, the seed/timeout race and a
// reset in the middle of a delivery. The expected grant order comes from a
// plain round-robin model (first set request at or after a pointer).
// ---------------------------------------------------------------------------
module tb_seed_request_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int SEED_W      = 8;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 50;
    localparam int RDY_LAT     = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int modelPtr    = 0;

    seed_request_arbiter_if #(.NUM_REQ(NUM_REQ), .SEED_W(SEED_W)) bus ();

    seed_request_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SEED_W     (SEED_W),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Last-resort guard so a stuck run still ends with a report.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Round-robin reference: first requester at or after ptr, with wrap.
    function automatic int pickWinner(input int ptr, input logic [NUM_REQ-1:0] mask);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitGenRun(input int limit, output int n);
        n = 0;
        while (bus.gen_run !== 1'b1) begin
            if (n >= limit) begin
                n = -1;
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic waitSeedValid(input int limit, output int n);
        n = 0;
        while (bus.seed_valid !== 1'b1) begin
            if (n >= limit) begin
                n = -1;
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++; if (bus.gnt !== '0) begin miscompares++; $display("[TB] FAIL reset_gnt: got %b, expected 0", bus.gnt); end
        vectors++; if (bus.seed_o !== '0) begin miscompares++; $display("[TB] FAIL reset_seed: got %h, expected 0", bus.seed_o); end
        vectors++; if (bus.seed_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", bus.seed_valid); end
        vectors++; if (bus.gen_run !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_run: got %b, expected 0", bus.gen_run); end
        vectors++; if (bus.gen_rate !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_rate: got %b, expected 000", bus.gen_rate); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
        vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tmo: got %b, expected 0", bus.timeout_err); end
        reset_n = 1'b1;
        repeat (3) tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL release_busy: got %b, expected 0", bus.busy); end
        modelPtr = 0;
    endtask

    task automatic test_single();
        int n;
        int w;
        logic [NUM_REQ-1:0] expGnt;
        bus.rate_sel      = (3*NUM_REQ)'($urandom);
        bus.rate_sel[2:0] = 3'b111;
        bus.gen_seed      = 8'hA5;
        bus.req           = 4'b0001;
        w      = pickWinner(modelPtr, bus.req);
        expGnt = NUM_REQ'(1) << w;
        tick();
        vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL single_gnt: got %b, expected %b", bus.gnt, expGnt); end
        vectors++; if (bus.gen_rate !== 3'b111) begin miscompares++; $display("[TB] FAIL single_rate: got %b, expected 111", bus.gen_rate); end
        for (int i = 1; i <= SETTLE_CYC; i++) begin
            tick();
            vectors++; if (bus.gen_run !== (i == SETTLE_CYC)) begin miscompares++; $display("[TB] FAIL single_settle: cycle %0d gen_run got %b, expected %b", i, bus.gen_run, (i == SETTLE_CYC)); end
            vectors++; if (bus.gen_rate !== 3'b111) begin miscompares++; $display("[TB] FAIL single_rate_hold: cycle %0d got %b, expected 111", i, bus.gen_rate); end
        end
        repeat (10) tick();
        bus.gen_ready = 1'b1;
        waitSeedValid(10, n);
        vectors++; if (n !== RDY_LAT) begin miscompares++; $display("[TB] FAIL single_latency: got %0d cycles, expected %0d", n, RDY_LAT); end
        vectors++; if (bus.seed_o !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_seed: got %h, expected a5", bus.seed_o); end
        vectors++; if (bus.gen_run !== 1'b0) begin miscompares++; $display("[TB] FAIL single_run_off: got %b, expected 0", bus.gen_run); end
        bus.ack[0] = 1'b1;
        tick();
        bus.ack       = '0;
        bus.req       = '0;
        bus.gen_ready = 1'b0;
        vectors++; if (bus.seed_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release_valid: got %b, expected 0", bus.seed_valid); end
        vectors++; if (bus.gnt !== '0) begin miscompares++; $display("[TB] FAIL single_release_gnt: got %b, expected 0", bus.gnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release_busy: got %b, expected 0", bus.busy); end
        modelPtr = (w + 1) % NUM_REQ;
    endtask

    // allReq=1 keeps every request raised; otherwise each transaction uses a
    // fresh random non-zero request mask. Transactions end either by ack or
    // by the granted requester dropping its request during delivery.
    task automatic test_round_robin(input int count, input bit allReq);
        int n;
        int w;
        int endHow;
        logic [NUM_REQ-1:0] expGnt;
        logic [NUM_REQ-1:0] mask;
        logic [SEED_W-1:0]  s;
        for (int t = 0; t < count; t++) begin
            if (allReq) begin
                mask = '1;
            end else begin
                do mask = NUM_REQ'($urandom); while (mask == '0);
            end
            bus.req      = mask;
            bus.rate_sel = (3*NUM_REQ)'($urandom);
            w      = pickWinner(modelPtr, mask);
            expGnt = NUM_REQ'(1) << w;
            tick();
            vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL rr_gnt: txn %0d got %b, expected %b", t, bus.gnt, expGnt); end
            vectors++; if (bus.gen_rate !== bus.rate_sel[3*w +: 3]) begin miscompares++; $display("[TB] FAIL rr_rate: txn %0d got %b, expected %b", t, bus.gen_rate, bus.rate_sel[3*w +: 3]); end
            waitGenRun(SETTLE_CYC + 4, n);
            vectors++; if (n !== SETTLE_CYC) begin miscompares++; $display("[TB] FAIL rr_settle: txn %0d got %0d cycles, expected %0d", t, n, SETTLE_CYC); end
            repeat ($urandom_range(0, 8)) tick();
            s             = SEED_W'($urandom);
            bus.gen_seed  = s;
            bus.gen_ready = 1'b1;
            waitSeedValid(10, n);
            vectors++; if (n !== RDY_LAT) begin miscompares++; $display("[TB] FAIL rr_latency: txn %0d got %0d cycles, expected %0d", t, n, RDY_LAT); end
            bus.ack = ~expGnt;
            tick();
            bus.ack = '0;
            vectors++; if (bus.seed_valid !== 1'b1 || bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL rr_foreign_ack: txn %0d valid %b gnt %b, expected 1 and %b", t, bus.seed_valid, bus.gnt, expGnt); end
            vectors++; if (bus.seed_o !== s) begin miscompares++; $display("[TB] FAIL rr_seed: txn %0d got %h, expected %h", t, bus.seed_o, s); end
            endHow = $urandom_range(0, 1);
            if (endHow == 0) bus.ack[w] = 1'b1;
            else             bus.req[w] = 1'b0;
            tick();
            bus.ack       = '0;
            bus.req       = '0;
            bus.gen_ready = 1'b0;
            vectors++; if (bus.gnt !== '0 || bus.seed_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_release: txn %0d gnt %b valid %b busy %b, expected all 0", t, bus.gnt, bus.seed_valid, bus.busy); end
            modelPtr = (w + 1) % NUM_REQ;
        end
    endtask

    task automatic test_timeout();
        int n;
        int w;
        int runDrops;
        logic [NUM_REQ-1:0] expGnt;
        bus.req = 4'b0010;
        w       = pickWinner(modelPtr, bus.req);
        expGnt  = NUM_REQ'(1) << w;
        tick();
        vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL tmo_gnt: got %b, expected %b", bus.gnt, expGnt); end
        waitGenRun(SETTLE_CYC + 4, n);
        vectors++; if (n !== SETTLE_CYC) begin miscompares++; $display("[TB] FAIL tmo_settle: got %0d cycles, expected %0d", n, SETTLE_CYC); end
        n        = 0;
        runDrops = 0;
        while (bus.timeout_err !== 1'b1 && n < TIMEOUT_CYC + 10) begin
            if (bus.gen_run !== 1'b1) runDrops++;
            tick();
            n++;
        end
        vectors++; if (n !== TIMEOUT_CYC) begin miscompares++; $display("[TB] FAIL tmo_when: pulse after %0d cycles, expected %0d", n, TIMEOUT_CYC); end
        vectors++; if (runDrops !== 0) begin miscompares++; $display("[TB] FAIL tmo_run_hold: gen_run low in %0d wait cycles, expected 0", runDrops); end
        vectors++; if (bus.gnt !== '0 || bus.gen_run !== 1'b0 || bus.seed_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_abort: gnt %b run %b valid %b, expected all 0", bus.gnt, bus.gen_run, bus.seed_valid); end
        modelPtr = (w + 1) % NUM_REQ;
        bus.req  = 4'b0110;
        w        = pickWinner(modelPtr, bus.req);
        expGnt   = NUM_REQ'(1) << w;
        tick();
        vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_pulse_width: got %b, expected 0", bus.timeout_err); end
        vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL tmo_next_gnt: got %b, expected %b", bus.gnt, expGnt); end
        bus.req = '0;
        tick();
        vectors++; if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_cfg_withdraw: gnt %b busy %b err %b, expected all 0", bus.gnt, bus.busy, bus.timeout_err); end
        modelPtr = (w + 1) % NUM_REQ;
    endtask

    task automatic test_withdrawal();
        int n;
        int w;
        logic [NUM_REQ-1:0] expGnt;
        bus.req = 4'b0100;
        w       = pickWinner(modelPtr, bus.req);
        expGnt  = NUM_REQ'(1) << w;
        tick();
        vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL wd_gnt: got %b, expected %b", bus.gnt, expGnt); end
        waitGenRun(SETTLE_CYC + 4, n);
        vectors++; if (n !== SETTLE_CYC) begin miscompares++; $display("[TB] FAIL wd_settle: got %0d cycles, expected %0d", n, SETTLE_CYC); end
        repeat (3) tick();
        bus.req = '0;
        tick();
        vectors++; if (bus.gnt !== '0 || bus.gen_run !== 1'b0) begin miscompares++; $display("[TB] FAIL wd_abort: gnt %b run %b, expected 0 and 0", bus.gnt, bus.gen_run); end
        vectors++; if (bus.timeout_err !== 1'b0 || bus.seed_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL wd_quiet: err %b valid %b busy %b, expected all 0", bus.timeout_err, bus.seed_valid, bus.busy); end
        modelPtr = (w + 1) % NUM_REQ;
        bus.req  = '1;
        w        = pickWinner(modelPtr, bus.req);
        expGnt   = NUM_REQ'(1) << w;
        tick();
        vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL wd_pointer: got %b, expected %b", bus.gnt, expGnt); end
        bus.req = '0;
        tick();
        vectors++; if (bus.gnt !== '0) begin miscompares++; $display("[TB] FAIL wd_cfg_abort: got %b, expected 0", bus.gnt); end
        modelPtr = (w + 1) % NUM_REQ;
    endtask

    // gen_ready is raised so its synchronized rising edge lands on the last
    // WAIT cycle, the one on which the timeout would otherwise fire.
    task automatic test_race();
        int n;
        int w;
        logic [NUM_REQ-1:0] mask;
        logic [SEED_W-1:0]  s;
        do mask = NUM_REQ'($urandom); while (mask == '0);
        bus.req      = mask;
        bus.rate_sel = (3*NUM_REQ)'($urandom);
        w            = pickWinner(modelPtr, mask);
        tick();
        vectors++; if (bus.gnt !== NUM_REQ'(1) << w) begin miscompares++; $display("[TB] FAIL race_gnt: got %b, expected index %0d", bus.gnt, w); end
        waitGenRun(SETTLE_CYC + 4, n);
        vectors++; if (n !== SETTLE_CYC) begin miscompares++; $display("[TB] FAIL race_settle: got %0d cycles, expected %0d", n, SETTLE_CYC); end
        repeat (TIMEOUT_CYC - RDY_LAT) tick();
        s             = SEED_W'($urandom);
        bus.gen_seed  = s;
        bus.gen_ready = 1'b1;
        for (int i = 1; i <= RDY_LAT + 1; i++) begin
            tick();
            vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL race_err: cycle %0d got %b, expected 0", i, bus.timeout_err); end
        end
        vectors++; if (bus.seed_valid !== 1'b1 || bus.seed_o !== s) begin miscompares++; $display("[TB] FAIL race_seed: valid %b seed %h, expected 1 and %h", bus.seed_valid, bus.seed_o, s); end
        bus.ack[w] = 1'b1;
        tick();
        bus.ack       = '0;
        bus.req       = '0;
        bus.gen_ready = 1'b0;
        vectors++; if (bus.gnt !== '0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL race_release: gnt %b busy %b, expected 0 and 0", bus.gnt, bus.busy); end
        modelPtr = (w + 1) % NUM_REQ;
    endtask

    task automatic test_reset_mid_deliver();
        int n;
        int w;
        logic [NUM_REQ-1:0] mask;
        do mask = NUM_REQ'($urandom); while (mask == '0);
        bus.req      = mask;
        bus.rate_sel = '1;
        w            = pickWinner(modelPtr, mask);
        tick();
        waitGenRun(SETTLE_CYC + 4, n);
        bus.gen_seed  = 8'h5A;
        bus.gen_ready = 1'b1;
        waitSeedValid(10, n);
        vectors++; if (bus.seed_valid !== 1'b1 || bus.gen_rate !== 3'b111) begin miscompares++; $display("[TB] FAIL rst_setup: valid %b rate %b, expected 1 and 111", bus.seed_valid, bus.gen_rate); end
        reset_n = 1'b0;
        #1;
        vectors++; if (bus.gnt !== '0 || bus.seed_valid !== 1'b0 || bus.seed_o !== '0) begin miscompares++; $display("[TB] FAIL rst_async_a: gnt %b valid %b seed %h, expected all 0", bus.gnt, bus.seed_valid, bus.seed_o); end
        vectors++; if (bus.gen_run !== 1'b0 || bus.gen_rate !== 3'b000 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_b: run %b rate %b busy %b err %b, expected all 0", bus.gen_run, bus.gen_rate, bus.busy, bus.timeout_err); end
        bus.req       = '0;
        bus.gen_ready = 1'b0;
        repeat (2) tick();
        reset_n  = 1'b1;
        repeat (3) tick();
        modelPtr = 0;
        bus.req  = 4'b1000;
        w        = pickWinner(modelPtr, bus.req);
        tick();
        vectors++; if (bus.gnt !== NUM_REQ'(1) << w) begin miscompares++; $display("[TB] FAIL rst_regrant: got %b, expected index %0d", bus.gnt, w); end
        bus.req = '0;
        tick();
        vectors++; if (bus.gnt !== '0 || bus.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cleanup: gnt %b err %b, expected 0 and 0", bus.gnt, bus.timeout_err); end
        modelPtr = (w + 1) % NUM_REQ;
    endtask

    initial begin
        bus.req       = '0;
        bus.rate_sel  = '0;
        bus.ack       = '0;
        bus.gen_seed  = '0;
        bus.gen_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin(5, 1'b1);
        test_timeout();
        test_withdrawal();
        test_race();
        test_round_robin(8, 1'b0);
        test_reset_mid_deliver();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
